// File: rtl/float_unit_pkg.sv
// Shared definitions for the fabric's float units: state encodings and
// width-generic float classification helpers.
package float_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DELAY = 2'd1,
        ST_ACCUM = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Helpers work on a 64-bit zero-extended container so any DATA_W up to 64 fits.
    function automatic logic [63:0] neg_inf(input int data_w, input int exp_w);
        logic [63:0] v;
        v = '0;
        for (int i = 0; i < 64; i++) begin
            if (i >= data_w - 1 - exp_w && i < data_w) v[i] = 1'b1;
        end
        return v;
    endfunction

    function automatic logic is_nan(input logic [63:0] x, input int data_w, input int exp_w);
        logic [63:0] exp_mask;
        logic [63:0] man_mask;
        exp_mask = '0;
        man_mask = '0;
        for (int i = 0; i < 64; i++) begin
            if (i < data_w - 1 - exp_w)  man_mask[i] = 1'b1;
            else if (i < data_w - 1)     exp_mask[i] = 1'b1;
        end
        return ((x & exp_mask) == exp_mask) && ((x & man_mask) != '0);
    endfunction

endpackage

// File: rtl/float_greater_than.sv
// Strict sign-magnitude "a > b" for IEEE-style floats; any NaN operand yields 0.
module float_greater_than
    import float_unit_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int EXP_W  = 8
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              gt
);

    localparam logic [DATA_W-1:0] SIGN_BIT = {1'b1, {(DATA_W-1){1'b0}}};

    logic [DATA_W-1:0] w_key_a;
    logic [DATA_W-1:0] w_key_b;
    logic              w_nan_a;
    logic              w_nan_b;

    // Map to an unsigned key whose natural order matches float order:
    // negatives are inverted (bigger magnitude -> smaller key), positives get the top bit.
    assign w_key_a = a[DATA_W-1] ? ~a : (a | SIGN_BIT);
    assign w_key_b = b[DATA_W-1] ? ~b : (b | SIGN_BIT);

    assign w_nan_a = is_nan(64'(a), DATA_W, EXP_W);
    assign w_nan_b = is_nan(64'(b), DATA_W, EXP_W);

    assign gt = !w_nan_a && !w_nan_b && (w_key_a > w_key_b);

endmodule

// File: rtl/float_arg_max_accum.sv
// Streaming arg-max reduction: folds a vector of floats into its maximum,
// the index where it first occurred, and a done/found status word.
module float_arg_max_accum
    import float_unit_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int EXP_W  = 8,
    parameter int IDX_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              running,
    input  logic              run,
    input  logic [DATA_W-1:0] in0,
    input  logic [IDX_W-1:0]  length,
    input  logic [IDX_W-1:0]  delay,
    output logic [DATA_W-1:0] out0,
    output logic [DATA_W-1:0] out1,
    output logic [DATA_W-1:0] out2
);

    localparam logic [DATA_W-1:0] NEG_INF = DATA_W'(neg_inf(DATA_W, EXP_W));

    state_t            r_state;
    logic [IDX_W-1:0]  r_len;
    logic [IDX_W-1:0]  r_dly;
    logic [IDX_W-1:0]  r_idx;
    logic [IDX_W-1:0]  r_arg;
    logic [DATA_W-1:0] r_max;
    logic              r_found;
    logic              r_done;

    logic              w_in_nan;
    logic              w_gt;
    logic              w_last;
    state_t            w_start_state;

    float_greater_than #(
        .DATA_W (DATA_W),
        .EXP_W  (EXP_W)
    ) u_gt (
        .a  (in0),
        .b  (r_max),
        .gt (w_gt)
    );

    assign w_in_nan = is_nan(64'(in0), DATA_W, EXP_W);
    assign w_last   = (r_idx == r_len - 1'b1);

    always_comb begin
        w_start_state = ST_DONE;
        if (delay != '0)       w_start_state = ST_DELAY;
        else if (length != '0) w_start_state = ST_ACCUM;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_len   <= '0;
            r_dly   <= '0;
            r_idx   <= '0;
            r_arg   <= '0;
            r_max   <= '0;
            r_found <= 1'b0;
            r_done  <= 1'b0;
        end else if (run) begin
            // A restart ignores running and discards any partial result.
            r_state <= w_start_state;
            r_len   <= length;
            r_dly   <= delay;
            r_idx   <= '0;
            r_arg   <= '0;
            r_max   <= NEG_INF;
            r_found <= 1'b0;
            r_done  <= (delay == '0) && (length == '0);
        end else if (running) begin
            case (r_state)
                ST_DELAY: begin
                    r_dly <= r_dly - 1'b1;
                    if (r_dly == IDX_W'(1)) begin
                        r_state <= (r_len == '0) ? ST_DONE : ST_ACCUM;
                        r_done  <= (r_len == '0);
                    end
                end
                ST_ACCUM: begin
                    if (!w_in_nan && (!r_found || w_gt)) begin
                        r_max   <= in0;
                        r_arg   <= r_idx;
                        r_found <= 1'b1;
                    end
                    if (w_last) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                ST_IDLE, ST_DONE: begin
                    r_state <= r_state;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign out0 = r_max;
    assign out1 = DATA_W'(r_arg);
    assign out2 = {{(DATA_W-2){1'b0}}, r_found, r_done};

endmodule

// File: tb/tb_float_arg_max_accum.sv
// Randomised scoreboard bench for float_arg_max_accum against a rule-level reference model.
module tb_float_arg_max_accum;

    logic        clk;
    logic        rst;
    logic        running;
    logic        run;
    logic [31:0] in0;
    logic [15:0] length;
    logic [15:0] delay;
    logic [31:0] out0;
    logic [31:0] out1;
    logic [31:0] out2;

    typedef struct {
        logic [31:0] o0;
        logic [31:0] o1;
        logic [31:0] o2;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    float_arg_max_accum #(.DATA_W(32), .EXP_W(8), .IDX_W(16)) dut (
        .clk     (clk),
        .rst     (rst),
        .running (running),
        .run     (run),
        .in0     (in0),
        .length  (length),
        .delay   (delay),
        .out0    (out0),
        .out1    (out1),
        .out2    (out2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference model: ordering rules stated directly on sign and magnitude.
    function automatic logic m_nan(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    endfunction

    function automatic logic m_gt(input logic [31:0] a, input logic [31:0] b);
        if (m_nan(a) || m_nan(b)) return 1'b0;
        if (a[31] != b[31])       return !a[31];
        if (!a[31])               return a[30:0] > b[30:0];
        return a[30:0] < b[30:0];
    endfunction

    function automatic exp_t model(input logic [31:0] vec[$]);
        exp_t e;
        logic found;
        e.o0 = 32'hFF800000;
        e.o1 = 32'd0;
        found = 1'b0;
        foreach (vec[i]) begin
            if (!m_nan(vec[i]) && (!found || m_gt(vec[i], e.o0))) begin
                e.o0 = vec[i];
                e.o1 = 32'(i);
                found = 1'b1;
            end
        end
        e.o2 = {30'd0, found, 1'b1};
        return e;
    endfunction

    // Monitor: each rising edge of the done bit is one completed reduction.
    initial begin
        logic prev_done;
        exp_t e;
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (out2[0] && !prev_done) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got out0=0x%08h out1=%0d with no reduction outstanding", out0, out1);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_out0", out0, e.o0);
                    chk("sb_out1", out1, e.o1);
                    chk("sb_out2", out2, e.o2);
                end
            end
            prev_done = out2[0];
        end
    end

    task automatic pulse_run(input int len, input int dly);
        run     = 1'b1;
        length  = 16'(len);
        delay   = 16'(dly);
        running = 1'($urandom_range(0, 1));
        in0     = $urandom;
        @(posedge clk); #1;
        run = 1'b0;
    endtask

    task automatic send_vec(input logic [31:0] vec[$], input int dly,
                            input int stall_at, input int stall_n);
        logic [31:0] h0;
        logic [31:0] h1;
        exp_q.push_back(model(vec));
        pulse_run(vec.size(), dly);
        chk("restart_out0", out0, 32'hFF800000);
        chk("restart_out2", out2, (vec.size() == 0 && dly == 0) ? 32'd1 : 32'd0);
        for (int d = 0; d < dly; d++) begin
            running = 1'b1;
            in0     = $urandom;
            @(posedge clk); #1;
        end
        for (int i = 0; i < vec.size(); i++) begin
            if (i == stall_at && stall_n > 0) begin
                h0 = out0;
                h1 = out1;
                for (int s = 0; s < stall_n; s++) begin
                    running = 1'b0;
                    in0     = $urandom;
                    @(posedge clk); #1;
                end
                chk("stall_hold_out0", out0, h0);
                chk("stall_hold_out1", out1, h1);
            end
            running = 1'b1;
            in0     = vec[i];
            @(posedge clk); #1;
        end
        running = 1'b0;
        chk("done_on_last_edge", {31'd0, out2[0]}, 32'd1);
    endtask

    task automatic start_partial(input int len, input int dly, input int n_feed,
                                 input logic [31:0] val);
        pulse_run(len, dly);
        for (int d = 0; d < dly; d++) begin
            running = 1'b1;
            in0     = $urandom;
            @(posedge clk); #1;
        end
        for (int i = 0; i < n_feed; i++) begin
            running = 1'b1;
            in0     = val;
            @(posedge clk); #1;
        end
    endtask

    function automatic logic [31:0] rand_elem();
        logic [31:0] specials[7];
        specials = '{32'h00000000, 32'h80000000, 32'h7F800000, 32'hFF800000,
                     32'h7FC00000, 32'h3F800000, 32'hBF800000};
        if ($urandom_range(0, 2) == 0) return specials[$urandom_range(0, 6)];
        return $urandom;
    endfunction

    initial begin
        logic [31:0] v[$];
        logic [31:0] v2[$];
        rst = 1'b1; run = 1'b0; running = 1'b0; in0 = '0; length = '0; delay = '0;
        #12;
        chk("reset_out0", out0, 32'd0);
        chk("reset_out1", out1, 32'd0);
        chk("reset_out2", out2, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 4; i++) begin
            running = 1'b1;
            in0     = 32'h40000000;
            @(posedge clk); #1;
        end
        chk("idle_no_sample_out0", out0, 32'd0);
        chk("idle_no_sample_out2", out2, 32'd0);

        v = '{32'h3F800000, 32'h40600000, 32'hC0000000, 32'h40000000};
        send_vec(v, 0, -1, 0);
        chk("basic_out0", out0, 32'h40600000);
        chk("basic_out1", out1, 32'd1);
        chk("basic_out2", out2, 32'd3);

        v = '{32'h80000000, 32'h00000000, 32'h00000000};
        send_vec(v, 0, -1, 0);
        chk("zero_tie_out0", out0, 32'h00000000);
        chk("zero_tie_out1", out1, 32'd1);

        v = '{32'h7FC00000, 32'hBF800000, 32'h7F800001};
        send_vec(v, 2, -1, 0);
        chk("nan_delay_out0", out0, 32'hBF800000);
        chk("nan_delay_out1", out1, 32'd1);
        chk("nan_delay_out2", out2, 32'd3);

        v = '{32'h7FC00000, 32'hFF800001};
        send_vec(v, 0, -1, 0);
        chk("all_nan_out0", out0, 32'hFF800000);
        chk("all_nan_out1", out1, 32'd0);
        chk("all_nan_out2", out2, 32'd1);

        // Restart into a zero-length vector so done visibly rises again.
        start_partial(5, 0, 0, 32'd0);
        v = {};
        send_vec(v, 0, -1, 0);
        chk("zero_len_out2", out2, 32'd1);
        chk("zero_len_out0", out0, 32'hFF800000);

        v = {};
        for (int i = 0; i < 8; i++) v.push_back(rand_elem());
        send_vec(v, 1, 4, 3);
        send_vec(v, 1, -1, 0);

        // Abort a vector holding huge values; they must not leak into the next result.
        start_partial(6, 0, 2, 32'h7F000000);
        v = '{32'h3F800000, 32'hC0000000, 32'h40000000};
        send_vec(v, 0, -1, 0);
        chk("restart_clean_out0", out0, 32'h40000000);
        chk("restart_clean_out1", out1, 32'd2);

        for (int t = 0; t < 25; t++) begin
            v2 = {};
            for (int i = 0; i < $urandom_range(1, 10); i++) v2.push_back(rand_elem());
            send_vec(v2, $urandom_range(0, 3),
                     ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 9)) : -1,
                     $urandom_range(1, 3));
        end

        start_partial(6, 1, 3, 32'h3F800000);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_out0", out0, 32'd0);
        chk("async_rst_out1", out1, 32'd0);
        chk("async_rst_out2", out2, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            running = 1'b1;
            in0     = 32'h40000000;
            @(posedge clk); #1;
        end
        chk("post_rst_idle_out0", out0, 32'd0);
        chk("post_rst_idle_out2", out2, 32'd0);

        v = '{32'hC0400000, 32'hBF800000, 32'hBF800000};
        send_vec(v, 0, -1, 0);
        chk("recover_out0", out0, 32'hBF800000);
        chk("recover_out1", out1, 32'd1);

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/float_arg_max_accum.md
# float_arg_max_accum

Streaming floating-point reduction unit for the Versat accelerator fabric. It consumes one IEEE-754-style value per active cycle on `in0` and tracks the running maximum and the index where it first occurred, for a configured vector length. It is the downstream consumer of the ordering that the fabric's float compare units produce: a compare unit emits per-element mask words, while this block folds a whole vector into a max value, its position, and a status word. It is started by `run` and advanced by `running`, like every other fabric unit.

## Interface
- `DATA_W`, 32: float word width; sign at `DATA_W-1`.
- `EXP_W`, 8: exponent width. Mantissa width is `DATA_W-EXP_W-1`.
- `IDX_W`, 16: width of the length, delay and index fields.
- `clk`  in  1: clock.
- `rst`  in  1: reset, asynchronous, active-high.
- `running`  in  1: global enable. While low, all state holds.
- `run`  in  1: single-cycle start pulse. Latches the config and restarts the reduction.
- `in0`  in  DATA_W: input float stream.
- `length`  in  IDX_W: number of elements to reduce. Sampled on `run`.
- `delay`  in  IDX_W: active cycles to skip before the first element. Sampled on `run`.
- `out0`  out  DATA_W: running or final maximum value.
- `out1`  out  DATA_W: index of the maximum, zero-extended.
- `out2`  out  DATA_W: status word. Bit 0 = done; bit 1 = found (at least one non-NaN element seen); other bits 0.

## Operation
- States: IDLE, DELAY, ACCUM, DONE.
- `run` in any state:
  - Loads `len_q=length` and `dly_q=delay`.
  - Clears `idx`, `found` and `done`.
  - Sets `out0` to NEG_INF = {1, all-ones exponent, zero mantissa} and `out1` to 0.
  - Next state is DELAY if `delay!=0`. Otherwise ACCUM if `length!=0`. Otherwise DONE.
  - `run` outranks `running`: a `run` with `running` low still restarts the unit.
- DELAY, with `running` high: decrement `dly_q`. When it reaches 1, go to ACCUM, or to DONE if `len_q==0`.
- ACCUM, with `running` high, sample `in0` as element `idx`:
  - NaN (exponent all ones, mantissa nonzero): ignored, but `idx` still advances.
  - Else if `!found` or `in0` is strictly greater than `out0`: update `out0=in0`, `out1=idx`, `found=1`.
  - Ties keep the earliest index.
  - When `idx==len_q-1`, go to DONE and set `done=1`. Otherwise `idx++`.
- Ordering:
  - Sign-magnitude ordering: positive beats negative.
  - Both positive: larger magnitude wins.
  - Both negative: smaller magnitude wins.
  - +0 > -0.
  - ±inf compare normally.
- DONE: all outputs hold until the next `run`.
- All NaN: `out0` stays NEG_INF, `out1=0`, `found=0`, `done=1`.
- `length` counts modulo `IDX_W`: max `2^IDX_W-1` elements.

## Timing
- Reset values: `out0=0`, `out1=0`, `out2=0`, state IDLE, all counters 0.
- Reset mid-operation aborts immediately. The unit stays in IDLE until the next `run`.
- Latency is 1 cycle: an element sampled at edge N is reflected in `out0`/`out1` after edge N.
- `done` rises on the same edge that the last element is sampled.
- The first element is sampled on the `delay+1`-th active cycle after the `run` edge.
- Cycles with `running` low are not counted and do not sample `in0`.
- `run` while busy aborts the current reduction. The new one starts cleanly, with no merging of old values.
- From IDLE, `running` alone does nothing.

## Structure
- Shared package `float_unit_pkg`, holding:
  - state encodings;
  - a `neg_inf(DATA_W, EXP_W)` constant function;
  - an `is_nan` function, which the other float units reuse.
- One combinational sub-module, `float_greater_than`:
  - inputs `a` and `b`, output `gt`;
  - strict ordering as above;
  - either input NaN gives 0.
- Top level: state register, delay and index counters, result registers.

## Test plan
- Basic max:
  - Stimulus: `length=4`, `delay=0`, stream 1.0 (0x3F800000), 3.5 (0x40600000), -2.0 (0xC0000000), 2.0 (0x40000000).
  - Response: `out0=0x40600000`, `out1=1`, `out2=3` after the 4th sample.
- Ties and zero sign:
  - Stimulus: `length=3`, stream -0 (0x80000000), +0 (0x00000000), +0.
  - Response: `out0=0x00000000`, `out1=1`.
- NaN and delay:
  - Stimulus: `delay=2`, `length=3`. Two garbage words of 0x7FFFFFFF, then 0x7FC00000, -1.0 (0xBF800000), 0x7F800001.
  - Response: `out0=0xBF800000`, `out1=1`, `out2=3`.
- All NaN, then zero length:
  - Stimulus: all-NaN `length=2`.
  - Response: `out0=0xFF800000`, `out2=1`.
  - Stimulus: `length=0`, `delay=0`.
  - Response: `out2=1` one cycle after `run`.
- Stall and restart:
  - Stimulus: `running` low for 3 cycles mid-vector.
  - Response: `idx` and outputs hold, and the final result matches the unstalled run.
  - Stimulus: `run` reasserted at `idx=2`.
  - Response: `out0` returns to NEG_INF and `out2=0`, and only the new vector determines the result.
- Reset mid-ACCUM:
  - Stimulus: assert `rst` asynchronously.
  - Response: all outputs read 0 immediately, and no sampling occurs until the next `run`.
